// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 window sequencer: default geometry,
// FSM state encoding and the window record layout.
package conv_pkg;

  localparam int unsigned CONV_IMG_W = 64;
  localparam int unsigned CONV_IMG_H = 64;
  localparam int unsigned CONV_PIX_W = 13;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } conv_state_t;

  // p0..p2 top row, p3..p5 middle row, p6..p8 bottom row; p4 is the centre
  typedef struct packed {
    logic [CONV_PIX_W-1:0] p0;
    logic [CONV_PIX_W-1:0] p1;
    logic [CONV_PIX_W-1:0] p2;
    logic [CONV_PIX_W-1:0] p3;
    logic [CONV_PIX_W-1:0] p4;
    logic [CONV_PIX_W-1:0] p5;
    logic [CONV_PIX_W-1:0] p6;
    logic [CONV_PIX_W-1:0] p7;
    logic [CONV_PIX_W-1:0] p8;
  } conv_win_t;

endpackage

// File: rtl/conv_window_sequencer_if.sv
// Pixel-in / window-out handshake bundle of the window sequencer.
// master: pixel source + kernel side; slave: the sequencer itself.
interface conv_window_sequencer_if #(
  parameter int unsigned PIX_W = conv_pkg::CONV_PIX_W
) ();

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic             out_last;
  logic             busy;
  logic             frame_done;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, p0, p1, p2, p3, p4, p5, p6, p7, p8,
           out_last, busy, frame_done
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, p0, p1, p2, p3, p4, p5, p6, p7, p8,
           out_last, busy, frame_done
  );

endinterface

// File: rtl/conv_line_buffer.sv
// One image row of delay: circular buffer, DEPTH entries of WIDTH bits.
// dout is the entry written DEPTH shifts ago; it is replaced by din on shift.
module conv_line_buffer #(
  parameter int unsigned DEPTH = conv_pkg::CONV_IMG_W,
  parameter int unsigned WIDTH = conv_pkg::CONV_PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  assign dout = mem[ptr];

  // storage: contents need no reset, they are written before being used
  always_ff @(posedge clk) begin
    if (shift_en) mem[ptr] <= din;
  end

  // read/write pointer wraps at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (shift_en) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// Raster-order pixel stream in, one registered 3x3 neighbourhood per pixel
// out, with border handling and end-of-frame flush.
// Optional build macro CONV_SEQ_REPLICATE_EN: out-of-frame taps replicate
// edge pixels (rows fixed first, then columns) instead of reading as zero.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = CONV_IMG_W,
  parameter int unsigned IMG_H = CONV_IMG_H,
  parameter int unsigned PIX_W = CONV_PIX_W
) (
  input logic                   clk,
  input logic                   rst_n,
  conv_window_sequencer_if.slave bus
);

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned SLAST = NPIX + IMG_W;      // final emitting step
  localparam int unsigned SMAX  = SLAST + 1;          // resting value after it
  localparam int unsigned SW    = $clog2(SMAX) + 1;
  localparam int unsigned CW    = $clog2(IMG_W) + 1;
  localparam int unsigned RW    = $clog2(IMG_H) + 1;

  conv_state_t state, state_nxt;

  logic [SW-1:0] s;
  logic [CW-1:0] o_col;
  logic [RW-1:0] o_row;

  logic emits, need_in, out_ok, in_ready_c, fire, hs_last;
  logic [PIX_W-1:0] x, lb1_out, lb2_out;

  // previous two columns of the raw neighbourhood, index 0 is the older
  logic [PIX_W-1:0] t_reg [2];
  logic [PIX_W-1:0] m_reg [2];
  logic [PIX_W-1:0] b_reg [2];

  logic [PIX_W-1:0] w  [9];
  logic [PIX_W-1:0] wm [9];
  logic [PIX_W-1:0] p_r [9];
  logic             out_valid_r, out_last_r;

  // line buffer 1 delays the stream by one row, line buffer 2 by two rows
  conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .shift_en(fire), .din(x), .dout(lb1_out)
  );

  conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
    .clk(clk), .rst_n(rst_n), .shift_en(fire), .din(lb1_out), .dout(lb2_out)
  );

  // step firing, handshake decode and FSM next state
  always_comb begin
    emits      = (s >= SW'(IMG_W + 1));
    need_in    = (s < SW'(NPIX));
    out_ok     = !out_valid_r || bus.out_ready;
    in_ready_c = (state != FLUSH) && (out_ok || !emits);
    fire       = 1'b0;
    if (need_in) fire = bus.in_valid && in_ready_c;
    else         fire = (state == FLUSH) && (s <= SW'(SLAST)) && out_ok;
    hs_last    = out_valid_r && bus.out_ready && out_last_r;
    x          = need_in ? bus.in_pixel : '0;

    state_nxt = state;
    case (state)
      IDLE:    if (fire) state_nxt = FILL;
      FILL:    if (fire && (s == SW'(IMG_W))) state_nxt = RUN;
      RUN:     if (fire && (s == SW'(NPIX - 1))) state_nxt = FLUSH;
      FLUSH:   if (hs_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // step counter and centre row/column of the next window to emit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s     <= '0;
      o_col <= '0;
      o_row <= '0;
    end else begin
      if (hs_last)   s <= '0;
      else if (fire) s <= s + SW'(1);
      if (fire && emits) begin
        if (o_col == CW'(IMG_W - 1)) begin
          o_col <= '0;
          o_row <= (o_row == RW'(IMG_H - 1)) ? '0 : o_row + RW'(1);
        end else begin
          o_col <= o_col + CW'(1);
        end
      end
    end
  end

  // raw neighbourhood column history, advanced on every fired step
  always_ff @(posedge clk) begin
    if (fire) begin
      t_reg[0] <= t_reg[1];
      t_reg[1] <= lb2_out;
      m_reg[0] <= m_reg[1];
      m_reg[1] <= lb1_out;
      b_reg[0] <= b_reg[1];
      b_reg[1] <= x;
    end
  end

  // window for the firing step: stored columns plus the column arriving now
  always_comb begin
    w[0] = t_reg[0]; w[1] = t_reg[1]; w[2] = lb2_out;
    w[3] = m_reg[0]; w[4] = m_reg[1]; w[5] = lb1_out;
    w[6] = b_reg[0]; w[7] = b_reg[1]; w[8] = x;
  end

  // border treatment of out-of-frame taps, including cross-row wrap taps
  always_comb begin
    for (int unsigned i = 0; i < 9; i++) wm[i] = w[i];
`ifdef CONV_SEQ_REPLICATE_EN
    if (o_row == '0) begin
      for (int unsigned c = 0; c < 3; c++) wm[c] = w[3 + c];
    end
    if (o_row == RW'(IMG_H - 1)) begin
      for (int unsigned c = 0; c < 3; c++) wm[6 + c] = w[3 + c];
    end
    // columns read the row-corrected values so corners resolve correctly
    if (o_col == '0) begin
      for (int unsigned r = 0; r < 3; r++) wm[3*r] = wm[3*r + 1];
    end
    if (o_col == CW'(IMG_W - 1)) begin
      for (int unsigned r = 0; r < 3; r++) wm[3*r + 2] = wm[3*r + 1];
    end
`else
    if (o_row == '0) begin
      for (int unsigned c = 0; c < 3; c++) wm[c] = '0;
    end
    if (o_row == RW'(IMG_H - 1)) begin
      for (int unsigned c = 0; c < 3; c++) wm[6 + c] = '0;
    end
    if (o_col == '0) begin
      for (int unsigned r = 0; r < 3; r++) wm[3*r] = '0;
    end
    if (o_col == CW'(IMG_W - 1)) begin
      for (int unsigned r = 0; r < 3; r++) wm[3*r + 2] = '0;
    end
`endif
  end

  // output window register: load on an emitting step, hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      for (int unsigned i = 0; i < 9; i++) p_r[i] <= '0;
    end else if (fire && emits) begin
      out_valid_r <= 1'b1;
      out_last_r  <= (o_row == RW'(IMG_H - 1)) && (o_col == CW'(IMG_W - 1));
      for (int unsigned i = 0; i < 9; i++) p_r[i] <= wm[i];
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_last   = out_last_r;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = hs_last;
  assign bus.p0 = p_r[0];
  assign bus.p1 = p_r[1];
  assign bus.p2 = p_r[2];
  assign bus.p3 = p_r[3];
  assign bus.p4 = p_r[4];
  assign bus.p5 = p_r[5];
  assign bus.p6 = p_r[6];
  assign bus.p7 = p_r[7];
  assign bus.p8 = p_r[8];

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer on a 64x64 ramp frame (pixel = row*64+col).
module tb_conv_window_sequencer;

  localparam int W = 64;
  localparam int H = 64;
  localparam int N = W * H;

  typedef logic [0:8][12:0] win_t;

  typedef struct {
    string name;
    int    row;
    int    col;
    win_t  p;
    bit    last;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_window_sequencer_if #(.PIX_W(13)) bus ();

  conv_window_sequencer #(.IMG_W(W), .IMG_H(H), .PIX_W(13)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  win_t cap [N];
  bit   cap_last [N];
  int   cnt, fd_cnt, last_cnt, stab_viol, flush_win, flush_viol;
  int   cyc = 0;
  int   first_ov_cyc = -1;
  int   acc65_edge = -2;
  bit   last_px_in;
  bit   bp = 1'b0;
  bit   prev_stall = 1'b0;
  win_t prev_win;
  logic prev_last;
  vec_t vecs [5];

  win_t cur_win;
  assign cur_win = {bus.p0, bus.p1, bus.p2, bus.p3, bus.p4,
                    bus.p5, bus.p6, bus.p7, bus.p8};

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_win(input string name, input win_t act, input win_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%p required=%p", name, act, exp);
    end
  endtask

  function automatic win_t mk(input int a0, input int a1, input int a2,
                              input int a3, input int a4, input int a5,
                              input int a6, input int a7, input int a8);
    win_t m;
    m[0] = 13'(a0); m[1] = 13'(a1); m[2] = 13'(a2);
    m[3] = 13'(a3); m[4] = 13'(a4); m[5] = 13'(a5);
    m[6] = 13'(a6); m[7] = 13'(a7); m[8] = 13'(a8);
    return m;
  endfunction

  // coordinate-based reference: tap (r+dr, c+dc) of the ramp frame
  function automatic win_t model(input int r, input int c);
    win_t m;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int rr = r + dr;
        int cc = c + dc;
        int v;
`ifdef CONV_SEQ_REPLICATE_EN
        if (rr < 0) rr = 0;
        if (rr > H - 1) rr = H - 1;
        if (cc < 0) cc = 0;
        if (cc > W - 1) cc = W - 1;
        v = rr * W + cc;
`else
        v = (rr < 0 || rr > H - 1 || cc < 0 || cc > W - 1) ? 0 : rr * W + cc;
`endif
        m[(dr + 1) * 3 + (dc + 1)] = 13'(v);
      end
    end
    return m;
  endfunction

  always @(posedge clk) cyc++;

  // monitor: sampled on the falling edge, i.e. what the next rising edge sees
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!bus.out_valid || cur_win !== prev_win || bus.out_last !== prev_last))
        stab_viol++;
      if (bus.out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (cnt < N) begin
          cap[cnt]      = cur_win;
          cap_last[cnt] = bus.out_last;
        end
        cnt++;
        if (bus.out_last) last_cnt++;
        if (last_px_in) flush_win++;
      end
      if (last_px_in && bus.busy && bus.in_ready) flush_viol++;
      if (bus.frame_done) fd_cnt++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_win   = cur_win;
      prev_last  = bus.out_last;
    end
  end

  // kernel side: always ready, or ready 30% of cycles under backpressure
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic clear_capture();
    cnt = 0; fd_cnt = 0; last_cnt = 0; stab_viol = 0;
    flush_win = 0; flush_viol = 0; first_ov_cyc = -1; last_px_in = 1'b0;
  endtask

  // sends the ramp frame; with abort_at >= 0 stops once that many pixels went in
  task automatic send_frame(input bit rnd, input int abort_at, output bit aborted);
    int idx = 0;
    int guard = 0;
    aborted = 1'b0;
    while (idx < N && guard < 60000) begin
      @(posedge clk);
      #1;
      if (abort_at >= 0 && idx == abort_at) begin
        aborted = 1'b1;
        bus.in_valid = 1'b0;
        return;
      end
      bus.in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_pixel = 13'(idx);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        if (idx == W + 1) acc65_edge = cyc + 1;
        idx++;
      end
      guard++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (idx == N) last_px_in = 1'b1;
    check("pixels_accepted", idx, N);
  endtask

  task automatic wait_done();
    int g = 0;
    while (fd_cnt == 0 && g < 20000) begin
      @(negedge clk);
      g++;
    end
    check("frame_done_seen", (fd_cnt > 0), 1);
    repeat (4) @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_out_valid", bus.out_valid, 0);
  endtask

  task automatic check_frame(input string tag);
    int mism = 0;
    check({tag, "_win_count"}, cnt, N);
    check({tag, "_frame_done_count"}, fd_cnt, 1);
    check({tag, "_last_count"}, last_cnt, 1);
    check({tag, "_last_on_final"}, cap_last[N-1], 1);
    check({tag, "_hold_stable"}, stab_viol, 0);
    for (int i = 0; i < N; i++) begin
      if (cap[i] !== model(i / W, i % W)) mism++;
    end
    check({tag, "_win_sequence"}, mism, 0);
    for (int v = 0; v < 5; v++) begin
      check_win({tag, "_", vecs[v].name}, cap[vecs[v].row * W + vecs[v].col], vecs[v].p);
      check({tag, "_", vecs[v].name, "_last"}, cap_last[vecs[v].row * W + vecs[v].col], vecs[v].last);
    end
  endtask

  initial begin
    bit ab;

`ifdef CONV_SEQ_REPLICATE_EN
    vecs[0] = '{name:"w0_0",   row:0,  col:0,  p:mk(0,0,1, 0,0,1, 64,64,65), last:1'b0};
    vecs[1] = '{name:"w10_20", row:10, col:20, p:mk(595,596,597, 659,660,661, 723,724,725), last:1'b0};
    vecs[2] = '{name:"w5_63",  row:5,  col:63, p:mk(318,319,319, 382,383,383, 446,447,447), last:1'b0};
    vecs[3] = '{name:"w6_0",   row:6,  col:0,  p:mk(320,320,321, 384,384,385, 448,448,449), last:1'b0};
    vecs[4] = '{name:"w63_63", row:63, col:63, p:mk(4030,4031,4031, 4094,4095,4095, 4094,4095,4095), last:1'b1};
`else
    vecs[0] = '{name:"w0_0",   row:0,  col:0,  p:mk(0,0,0, 0,0,1, 0,64,65), last:1'b0};
    vecs[1] = '{name:"w10_20", row:10, col:20, p:mk(595,596,597, 659,660,661, 723,724,725), last:1'b0};
    vecs[2] = '{name:"w5_63",  row:5,  col:63, p:mk(318,319,0, 382,383,0, 446,447,0), last:1'b0};
    vecs[3] = '{name:"w6_0",   row:6,  col:0,  p:mk(0,320,321, 0,384,385, 0,448,449), last:1'b0};
    vecs[4] = '{name:"w63_63", row:63, col:63, p:mk(4030,4031,0, 4094,4095,0, 0,0,0), last:1'b1};
`endif

    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    clear_capture();

    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check_win("rst_window", cur_win, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ramp frame at full rate
    clear_capture();
    send_frame(1'b0, -1, ab);
    wait_done();
    check("first_out_valid_cycle", first_ov_cyc, acc65_edge);
    // window 4030 (made by the last pixel) plus the 65 flush-only windows
    check("flush_windows", flush_win, W + 2);
    check("flush_in_ready_low", flush_viol, 0);
    check_frame("ramp");

    // random in_valid and 30% out_ready
    clear_capture();
    bp = 1'b1;
    send_frame(1'b1, -1, ab);
    wait_done();
    bp = 1'b0;
    check_frame("bp");

    // reset after 2000 pixels, then a full frame
    clear_capture();
    send_frame(1'b0, 2000, ab);
    check("abort_reached", ab, 1);
    check("abort_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_in_ready", bus.in_ready, 1);
    check("async_out_valid", bus.out_valid, 0);
    check("async_busy", bus.busy, 0);
    check("async_out_last", bus.out_last, 0);
    check_win("async_window", cur_win, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_frame_done", fd_cnt, 0);
    check("abort_idle_out_valid", bus.out_valid, 0);
    clear_capture();
    send_frame(1'b0, -1, ab);
    wait_done();
    check_frame("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
